bracket_matcher: RTL
====================

# bracket_matcher

Post-load pass between the program loader and the Brainfuck core. Once the loader signals the program image is complete, this block scans program memory from address 0 to PROG_LEN inclusive and pairs every `[` (0x5B) with its `]` (0x5D) using an internal address stack. For each matched pair it writes both directions into a jump table, so the core can take branches in one lookup. It flags unbalanced or too-deeply-nested programs so the core is never started.

## Interface
- PROG_ADDR_WIDTH, 12, width of program and jump-table addresses
- PROG_LEN, 4095, last valid program address; the scan covers 0..PROG_LEN inclusive
- STACK_DEPTH, 64, maximum nesting depth; internal register stack
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  begin a scan; sampled in IDLE, DONE and ERROR only; connect to the loader's `loaded`
- prog_rd_addr  output  PROG_ADDR_WIDTH  program memory read address (registered)
- prog_rd_data  input  8  program byte, valid one cycle after prog_rd_addr (synchronous read)
- jt_we  output  1  jump-table write strobe
- jt_addr  output  PROG_ADDR_WIDTH  jump-table write address
- jt_data  output  PROG_ADDR_WIDTH  jump-table write data (partner bracket address)
- done  output  1  scan finished with all brackets balanced; held until the next start
- error  output  1  scan aborted; held until the next start
- err_code  output  2  0 none, 1 unmatched `]`, 2 unmatched `[`, 3 stack overflow
- err_addr  output  PROG_ADDR_WIDTH  address at which the error was detected

## Operation
- States: IDLE, FETCH, EXAMINE, WRITE2, DONE, ERROR.
- IDLE, DONE or ERROR with start=1:
  - clear done, error, err_code, err_addr and sp;
  - set addr=0;
  - go to FETCH.
- FETCH: prog_rd_addr = addr; go to EXAMINE.
- EXAMINE, byte 0x5B:
  - if sp==STACK_DEPTH: go to ERROR with code 3, err_addr=addr;
  - otherwise push addr.
- EXAMINE, byte 0x5D:
  - if sp==0: go to ERROR with code 1, err_addr=addr;
  - otherwise pop open=top, issue jt write (addr=addr, data=open), latch open, go to WRITE2.
- EXAMINE, any other byte: no action.
- WRITE2: issue jt write (addr=open, data=addr).
- End check (EXAMINE without a `]` pop, or WRITE2):
  - if addr==PROG_LEN: go to DONE if sp==0, else ERROR with code 2, err_addr=PROG_LEN;
  - otherwise addr+1, go to FETCH.
- Stack pointer sp is $clog2(STACK_DEPTH)+1 bits wide. Overflow and underflow are detected before push or pop, so sp never wraps.
- The addr==PROG_LEN comparison happens before any increment, so addr never wraps even when PROG_LEN=2^PROG_ADDR_WIDTH-1.
- start is ignored in FETCH, EXAMINE and WRITE2.
- Jump-table entries for non-bracket addresses are not written.

## Timing
- Reset values: state=IDLE, sp=0, prog_rd_addr=0, jt_we=0, jt_addr=0, jt_data=0, done=0, error=0, err_code=0, err_addr=0.
- Reset mid-scan aborts immediately. Partial jump-table contents are left as-is; re-run to rebuild.
- All outputs are registered.
- jt_we is high for exactly one cycle per write. Each matched pair produces two writes on consecutive cycles: first at the `]` address, then at the `[` address.
- Per byte: 2 cycles; a `]` byte takes 3.
- With the start-sampling edge as edge 0 and N=PROG_LEN+1, done rises 2N+(number of `]`) edges later.
- The final jt write can coincide with the cycle done goes high.
- error, err_code and err_addr rise together on the edge leaving EXAMINE. No jt write is issued on that cycle.
- start asserted in DONE or ERROR restarts the scan: done/error drop on the next edge.

## Test plan
- PROG_LEN=2, image "[+]", pulse start:
  - jt[2]=0, then jt[0]=2, on consecutive cycles;
  - done rises at edge 7; error=0.
- PROG_LEN=3, image "[[]]":
  - writes in order jt[2]=1, jt[1]=2, jt[3]=0, jt[0]=3;
  - done at edge 10.
- PROG_LEN=0, image "]":
  - error=1, err_code=1, err_addr=0 at edge 2;
  - no jt_we pulse; done stays 0.
- PROG_LEN=1, image "[[":
  - error=1, err_code=2, err_addr=1 at edge 4;
  - no jt_we.
- STACK_DEPTH=2, PROG_LEN=3, image "[[[]":
  - error at addr 2, err_code=3;
  - start during the scan is ignored;
  - start while in ERROR clears error and rescans.
- Assert reset during WRITE2 of "[+]":
  - all outputs 0 that cycle and state IDLE;
  - a new start completes normally with done at edge 7.

Source files
------------

// File: rtl/bracket_matcher_if.sv
// Handshake and bus bundle between the bracket matcher, program memory, jump table
// and the core.
interface bracket_matcher_if #(
  parameter int unsigned AW = 12
);
  logic          start;
  logic [AW-1:0] prog_rd_addr;
  logic [7:0]    prog_rd_data;
  logic          jt_we;
  logic [AW-1:0] jt_addr;
  logic [AW-1:0] jt_data;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW-1:0] err_addr;

  modport master (
    input  start, prog_rd_data,
    output prog_rd_addr, jt_we, jt_addr, jt_data, done, error, err_code, err_addr
  );

  modport slave (
    output start, prog_rd_data,
    input  prog_rd_addr, jt_we, jt_addr, jt_data, done, error, err_code, err_addr
  );
endinterface

// File: rtl/bracket_matcher.sv
// Post-load scan pairing '[' and ']' in program memory and writing both jump directions
// into the jump table; flags unbalanced or over-nested programs.
module bracket_matcher #(
  parameter int unsigned PROG_ADDR_WIDTH = 12,
  parameter int unsigned PROG_LEN        = 4095,
  parameter int unsigned STACK_DEPTH     = 64
) (
  input logic                clk,
  input logic                reset,
  bracket_matcher_if.master  bus
);

  localparam int unsigned SpW  = $clog2(STACK_DEPTH) + 1;
  localparam int unsigned IdxW = SpW - 1;
  localparam logic [PROG_ADDR_WIDTH-1:0] LastAddr = PROG_ADDR_WIDTH'(PROG_LEN);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StFetch   = 3'd1;
  localparam logic [2:0] StExamine = 3'd2;
  localparam logic [2:0] StWrite2  = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;
  localparam logic [2:0] StError   = 3'd5;

  logic [2:0]                 state_q, state_d;
  logic [PROG_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PROG_ADDR_WIDTH-1:0] open_q, open_d;
  logic [SpW-1:0]             sp_q, sp_d;
  logic [PROG_ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                       jt_we_q, jt_we_d;
  logic [PROG_ADDR_WIDTH-1:0] jt_addr_q, jt_addr_d;
  logic [PROG_ADDR_WIDTH-1:0] jt_data_q, jt_data_d;
  logic                       done_q, done_d;
  logic                       error_q, error_d;
  logic [1:0]                 err_code_q, err_code_d;
  logic [PROG_ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic [PROG_ADDR_WIDTH-1:0] stack_q [STACK_DEPTH];
  logic [PROG_ADDR_WIDTH-1:0] top;
  logic                       push;
  logic                       end_chk;

  assign top = stack_q[IdxW'(sp_q - 1'b1)];

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    open_d     = open_q;
    sp_d       = sp_q;
    rd_addr_d  = rd_addr_q;
    jt_we_d    = 1'b0;
    jt_addr_d  = jt_addr_q;
    jt_data_d  = jt_data_q;
    done_d     = done_q;
    error_d    = error_q;
    err_code_d = err_code_q;
    err_addr_d = err_addr_q;
    push       = 1'b0;
    end_chk    = 1'b0;

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (bus.start) begin
          done_d     = 1'b0;
          error_d    = 1'b0;
          err_code_d = 2'd0;
          err_addr_d = '0;
          sp_d       = '0;
          addr_d     = '0;
          rd_addr_d  = '0;
          state_d    = StFetch;
        end
      end
      // Read address was presented on entry, so the synchronous read lands for EXAMINE.
      StFetch: state_d = StExamine;
      StExamine: begin
        if (bus.prog_rd_data == 8'h5B) begin
          if (sp_q == SpW'(STACK_DEPTH)) begin
            error_d    = 1'b1;
            err_code_d = 2'd3;
            err_addr_d = addr_q;
            state_d    = StError;
          end else begin
            push    = 1'b1;
            sp_d    = sp_q + 1'b1;
            end_chk = 1'b1;
          end
        end else if (bus.prog_rd_data == 8'h5D) begin
          if (sp_q == '0) begin
            error_d    = 1'b1;
            err_code_d = 2'd1;
            err_addr_d = addr_q;
            state_d    = StError;
          end else begin
            sp_d      = sp_q - 1'b1;
            jt_we_d   = 1'b1;
            jt_addr_d = addr_q;
            jt_data_d = top;
            open_d    = top;
            state_d   = StWrite2;
          end
        end else begin
          end_chk = 1'b1;
        end
      end
      StWrite2: begin
        jt_we_d   = 1'b1;
        jt_addr_d = open_q;
        jt_data_d = addr_q;
        end_chk   = 1'b1;
      end
      default: state_d = StIdle;
    endcase

    // Compare before incrementing so addr never wraps at the top of the address space.
    if (end_chk) begin
      if (addr_q == LastAddr) begin
        if (sp_d == '0) begin
          done_d  = 1'b1;
          state_d = StDone;
        end else begin
          error_d    = 1'b1;
          err_code_d = 2'd2;
          err_addr_d = LastAddr;
          state_d    = StError;
        end
      end else begin
        addr_d    = addr_q + 1'b1;
        rd_addr_d = addr_q + 1'b1;
        state_d   = StFetch;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      open_q     <= '0;
      sp_q       <= '0;
      rd_addr_q  <= '0;
      jt_we_q    <= 1'b0;
      jt_addr_q  <= '0;
      jt_data_q  <= '0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      err_code_q <= 2'd0;
      err_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      open_q     <= open_d;
      sp_q       <= sp_d;
      rd_addr_q  <= rd_addr_d;
      jt_we_q    <= jt_we_d;
      jt_addr_q  <= jt_addr_d;
      jt_data_q  <= jt_data_d;
      done_q     <= done_d;
      error_q    <= error_d;
      err_code_q <= err_code_d;
      err_addr_q <= err_addr_d;
    end
  end

  // Stack storage needs no reset: entries above sp are never read.
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[IdxW-1:0]] <= addr_q;
  end

  assign bus.prog_rd_addr = rd_addr_q;
  assign bus.jt_we        = jt_we_q;
  assign bus.jt_addr      = jt_addr_q;
  assign bus.jt_data      = jt_data_q;
  assign bus.done         = done_q;
  assign bus.error        = error_q;
  assign bus.err_code     = err_code_q;
  assign bus.err_addr     = err_addr_q;

endmodule
